// File: rtl/instr_fetch_dual.sv
// instr_fetch_dual: dual-path instruction fetch stage.
// After a conditional branch is issued, the fall-through stream (slot 0) and
// the branch-target stream (slot 1) are fetched side by side until the memory
// stage resolves the branch. jal is followed directly; jalr and exceptions
// arrive through flush/redirect_pc. The imem is a dual-port asynchronous ROM,
// so the addresses are combinational from the PC registers and the fetched
// words are captured into the IF/ID registers on the next edge.
module instr_fetch_dual (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        resolve_valid,
    input  logic        taken,
    output logic [31:0] imem_addr_0,
    output logic [31:0] imem_addr_1,
    input  logic [31:0] imem_data_0,
    input  logic [31:0] imem_data_1,
    output logic [31:0] PC_out_0,
    output logic [31:0] PC_out_1,
    output logic [31:0] instruction_out_0,
    output logic [31:0] instruction_out_1,
    output logic        dual_pending
);

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'h0000_0004;
    localparam logic [6:0]  OPC_BR   = 7'b1100011;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        ST_SINGLE = 2'd0,
        ST_DUAL   = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pre-decode helpers
    // ------------------------------------------------------------------
    function automatic logic is_br(input logic [31:0] w);
        is_br = (w[6:0] == OPC_BR);
    endfunction

    function automatic logic is_jal(input logic [31:0] w);
        is_jal = (w[6:0] == OPC_JAL);
    endfunction

    // Sign-extended B-type immediate (conditional branches).
    function automatic logic [31:0] b_imm(input logic [31:0] w);
        b_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate (jal).
    function automatic logic [31:0] j_imm(input logic [31:0] w);
        j_imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // State and IF/ID registers
    // ------------------------------------------------------------------
    state_t      state_r;
    logic [31:0] pc_0_r;
    logic [31:0] pc_1_r;
    logic [31:0] pc_out_0_r;
    logic [31:0] pc_out_1_r;
    logic [31:0] instr_out_0_r;
    logic [31:0] instr_out_1_r;
    logic        dual_pending_r;

    state_t      state_nxt_s;
    logic [31:0] pc_0_nxt_s;
    logic [31:0] pc_1_nxt_s;
    logic [31:0] pc_out_0_nxt_s;
    logic [31:0] pc_out_1_nxt_s;
    logic [31:0] instr_out_0_nxt_s;
    logic [31:0] instr_out_1_nxt_s;

    // Path chosen by a resolving branch and the word fetched on that path.
    logic [31:0] chosen_pc_s;
    logic [31:0] chosen_word_s;

    // Fetch addresses: both ports follow pc_0 until a second stream exists.
    always_comb begin
        imem_addr_0 = pc_0_r;
        case (state_r)
            ST_SINGLE: imem_addr_1 = pc_0_r;
            ST_DUAL:   imem_addr_1 = pc_1_r;
            ST_WAIT:   imem_addr_1 = pc_1_r;
            default:   imem_addr_1 = pc_0_r;
        endcase
    end

    // Select the surviving stream when the branch resolves.
    always_comb begin
        if (taken) begin
            chosen_pc_s   = pc_1_r;
            chosen_word_s = imem_data_1;
        end else begin
            chosen_pc_s   = pc_0_r;
            chosen_word_s = imem_data_0;
        end
    end

    // Next-state, next-PC and next-output logic (flush > resolve > stall > issue).
    always_comb begin
        state_nxt_s       = state_r;
        pc_0_nxt_s        = pc_0_r;
        pc_1_nxt_s        = pc_1_r;
        pc_out_0_nxt_s    = pc_out_0_r;
        pc_out_1_nxt_s    = pc_out_1_r;
        instr_out_0_nxt_s = instr_out_0_r;
        instr_out_1_nxt_s = instr_out_1_r;

        if (flush) begin
            // Redirect: drop everything in flight, including a same-cycle resolve.
            state_nxt_s       = ST_SINGLE;
            pc_0_nxt_s        = redirect_pc;
            pc_1_nxt_s        = redirect_pc;
            pc_out_0_nxt_s    = 32'h0000_0000;
            pc_out_1_nxt_s    = 32'h0000_0000;
            instr_out_0_nxt_s = NOP;
            instr_out_1_nxt_s = NOP;
        end else if (resolve_valid && (state_r != ST_SINGLE)) begin
            if (!stall) begin
                // Collapse onto the chosen stream and issue its word in the same edge.
                pc_out_0_nxt_s    = chosen_pc_s;
                pc_out_1_nxt_s    = chosen_pc_s;
                instr_out_0_nxt_s = chosen_word_s;
                instr_out_1_nxt_s = chosen_word_s;
                if (is_br(chosen_word_s)) begin
                    state_nxt_s = ST_DUAL;
                    pc_0_nxt_s  = chosen_pc_s + PC_STEP;
                    pc_1_nxt_s  = chosen_pc_s + b_imm(chosen_word_s);
                end else if (is_jal(chosen_word_s)) begin
                    state_nxt_s = ST_SINGLE;
                    pc_0_nxt_s  = chosen_pc_s + j_imm(chosen_word_s);
                    pc_1_nxt_s  = chosen_pc_s + j_imm(chosen_word_s);
                end else begin
                    state_nxt_s = ST_SINGLE;
                    pc_0_nxt_s  = chosen_pc_s + PC_STEP;
                    pc_1_nxt_s  = chosen_pc_s + PC_STEP;
                end
            end else begin
                // Stalled resolve: keep outputs, park on the chosen PC for a later re-fetch.
                state_nxt_s = ST_SINGLE;
                pc_0_nxt_s  = chosen_pc_s;
                pc_1_nxt_s  = chosen_pc_s;
            end
        end else if (stall) begin
            // Hazard hold: every register keeps its value.
            state_nxt_s = state_r;
            pc_0_nxt_s  = pc_0_r;
            pc_1_nxt_s  = pc_1_r;
        end else begin
            case (state_r)
                ST_SINGLE: begin
                    pc_out_0_nxt_s    = pc_0_r;
                    pc_out_1_nxt_s    = pc_0_r;
                    instr_out_0_nxt_s = imem_data_0;
                    instr_out_1_nxt_s = imem_data_0;
                    if (is_br(imem_data_0)) begin
                        state_nxt_s = ST_DUAL;
                        pc_0_nxt_s  = pc_0_r + PC_STEP;
                        pc_1_nxt_s  = pc_0_r + b_imm(imem_data_0);
                    end else if (is_jal(imem_data_0)) begin
                        state_nxt_s = ST_SINGLE;
                        pc_0_nxt_s  = pc_0_r + j_imm(imem_data_0);
                        pc_1_nxt_s  = pc_0_r + j_imm(imem_data_0);
                    end else begin
                        state_nxt_s = ST_SINGLE;
                        pc_0_nxt_s  = pc_0_r + PC_STEP;
                        pc_1_nxt_s  = pc_0_r + PC_STEP;
                    end
                end
                ST_DUAL: begin
                    if (is_br(imem_data_0) || is_jal(imem_data_0) ||
                        is_br(imem_data_1) || is_jal(imem_data_1)) begin
                        // A second control transfer would need a third stream: stop and wait.
                        state_nxt_s       = ST_WAIT;
                        pc_out_0_nxt_s    = 32'h0000_0000;
                        pc_out_1_nxt_s    = 32'h0000_0000;
                        instr_out_0_nxt_s = NOP;
                        instr_out_1_nxt_s = NOP;
                    end else begin
                        state_nxt_s       = ST_DUAL;
                        pc_out_0_nxt_s    = pc_0_r;
                        pc_out_1_nxt_s    = pc_1_r;
                        instr_out_0_nxt_s = imem_data_0;
                        instr_out_1_nxt_s = imem_data_1;
                        pc_0_nxt_s        = pc_0_r + PC_STEP;
                        pc_1_nxt_s        = pc_1_r + PC_STEP;
                    end
                end
                ST_WAIT: begin
                    state_nxt_s       = ST_WAIT;
                    pc_out_0_nxt_s    = 32'h0000_0000;
                    pc_out_1_nxt_s    = 32'h0000_0000;
                    instr_out_0_nxt_s = NOP;
                    instr_out_1_nxt_s = NOP;
                end
                default: begin
                    // Unreachable encoding: recover to a clean single stream.
                    state_nxt_s       = ST_SINGLE;
                    pc_1_nxt_s        = pc_0_r;
                    pc_out_0_nxt_s    = 32'h0000_0000;
                    pc_out_1_nxt_s    = 32'h0000_0000;
                    instr_out_0_nxt_s = NOP;
                    instr_out_1_nxt_s = NOP;
                end
            endcase
        end
    end

    // State, PC and IF/ID register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_SINGLE;
            pc_0_r         <= RESET_PC;
            pc_1_r         <= RESET_PC;
            pc_out_0_r     <= 32'h0000_0000;
            pc_out_1_r     <= 32'h0000_0000;
            instr_out_0_r  <= NOP;
            instr_out_1_r  <= NOP;
            dual_pending_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pc_0_r         <= pc_0_nxt_s;
            pc_1_r         <= pc_1_nxt_s;
            pc_out_0_r     <= pc_out_0_nxt_s;
            pc_out_1_r     <= pc_out_1_nxt_s;
            instr_out_0_r  <= instr_out_0_nxt_s;
            instr_out_1_r  <= instr_out_1_nxt_s;
            dual_pending_r <= (state_nxt_s != ST_SINGLE);
        end
    end

    assign PC_out_0          = pc_out_0_r;
    assign PC_out_1          = pc_out_1_r;
    assign instruction_out_0 = instr_out_0_r;
    assign instruction_out_1 = instr_out_1_r;
    assign dual_pending      = dual_pending_r;

endmodule

// File: tb/tb_instr_fetch_dual.sv
// Directed bench for instr_fetch_dual with a behavioural dual-port imem.
module tb_instr_fetch_dual;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0863;  // beq x0,x0,16
    localparam logic [31:0] JAL8 = 32'h0080_006F;  // jal x0,8

    logic        clk = 1'b0;
    logic        reset, stall, flush, resolve_valid, taken;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr_0, imem_addr_1, imem_data_0, imem_data_1;
    logic [31:0] PC_out_0, PC_out_1, instruction_out_0, instruction_out_1;
    logic        dual_pending;

    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;

    assign imem_data_0 = mem[imem_addr_0[9:2]];
    assign imem_data_1 = mem[imem_addr_1[9:2]];

    instr_fetch_dual dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .resolve_valid(resolve_valid), .taken(taken),
        .imem_addr_0(imem_addr_0), .imem_addr_1(imem_addr_1),
        .imem_data_0(imem_data_0), .imem_data_1(imem_data_1),
        .PC_out_0(PC_out_0), .PC_out_1(PC_out_1),
        .instruction_out_0(instruction_out_0), .instruction_out_1(instruction_out_1),
        .dual_pending(dual_pending)
    );

    always #5 clk = ~clk;

    // Every word defaults to a distinct addi x0,x0,<index>.
    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = {12'(i), 20'h00013};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both slots carry instructions fetched from the given PCs.
    task automatic chk_pair(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                            input logic dp);
        cmp({tag, ".pc0"}, PC_out_0, p0);
        cmp({tag, ".pc1"}, PC_out_1, p1);
        cmp({tag, ".in0"}, instruction_out_0, mem[p0[9:2]]);
        cmp({tag, ".in1"}, instruction_out_1, mem[p1[9:2]]);
        cmp({tag, ".dp"}, {31'd0, dual_pending}, {31'd0, dp});
    endtask

    task automatic chk_nop(input string tag, input logic dp);
        cmp({tag, ".pc0"}, PC_out_0, 32'h0);
        cmp({tag, ".pc1"}, PC_out_1, 32'h0);
        cmp({tag, ".in0"}, instruction_out_0, NOP);
        cmp({tag, ".in1"}, instruction_out_1, NOP);
        cmp({tag, ".dp"}, {31'd0, dual_pending}, {31'd0, dp});
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; resolve_valid = 1'b0; taken = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---- reset and sequential code, with a SINGLE-mode stall ----
        init_mem();
        do_reset();
        chk_nop("reset", 1'b0);
        cmp("reset.addr0", imem_addr_0, 32'h0);
        cmp("reset.addr1", imem_addr_1, 32'h0);
        tick(); chk_pair("seq0", 32'h0, 32'h0, 1'b0);
        tick(); chk_pair("seq1", 32'h4, 32'h4, 1'b0);
        tick(); chk_pair("seq2", 32'h8, 32'h8, 1'b0);
        stall = 1'b1;
        tick(); chk_pair("seq_stall", 32'h8, 32'h8, 1'b0);
        stall = 1'b0;
        tick(); chk_pair("seq3", 32'hC, 32'hC, 1'b0);

        // ---- branch resolved taken ----
        init_mem(); mem[1] = BEQ;
        do_reset();
        tick(); chk_pair("bt0", 32'h0, 32'h0, 1'b0);
        tick(); chk_pair("bt_br", 32'h4, 32'h4, 1'b1);
        tick(); chk_pair("bt_d0", 32'h8, 32'h14, 1'b1);
        cmp("bt.addr0", imem_addr_0, 32'hC);
        cmp("bt.addr1", imem_addr_1, 32'h18);
        tick(); chk_pair("bt_d1", 32'hC, 32'h18, 1'b1);
        resolve_valid = 1'b1; taken = 1'b1;
        tick(); chk_pair("bt_res", 32'h1C, 32'h1C, 1'b0);
        resolve_valid = 1'b0; taken = 1'b0;
        tick(); chk_pair("bt_next", 32'h20, 32'h20, 1'b0);

        // ---- same branch resolved not taken ----
        do_reset();
        tick(); tick(); tick(); tick();
        chk_pair("bn_d1", 32'hC, 32'h18, 1'b1);
        resolve_valid = 1'b1; taken = 1'b0;
        tick(); chk_pair("bn_res", 32'h10, 32'h10, 1'b0);
        resolve_valid = 1'b0;
        tick(); chk_pair("bn_next", 32'h14, 32'h14, 1'b0);

        // ---- jal in SINGLE ----
        init_mem(); mem[2] = JAL8;
        do_reset();
        tick(); tick();
        tick(); chk_pair("jal", 32'h8, 32'h8, 1'b0);
        tick(); chk_pair("jal_tgt", 32'h10, 32'h10, 1'b0);

        // ---- second branch in DUAL, stalled resolve ----
        init_mem(); mem[1] = BEQ; mem[6] = BEQ;
        do_reset();
        tick(); tick();
        tick(); chk_pair("w_d0", 32'h8, 32'h14, 1'b1);
        tick(); chk_nop("w_enter", 1'b1);
        tick(); chk_nop("w_hold", 1'b1);
        stall = 1'b1; resolve_valid = 1'b1; taken = 1'b0;
        tick(); chk_nop("w_stall_res", 1'b0);
        cmp("w.addr1", imem_addr_1, 32'hC);
        stall = 1'b0; resolve_valid = 1'b0;
        tick(); chk_pair("w_refetch", 32'hC, 32'hC, 1'b0);

        // ---- flush wins over a same-cycle resolve ----
        init_mem(); mem[1] = BEQ;
        do_reset();
        tick(); tick(); tick(); tick();
        chk_pair("f_d1", 32'hC, 32'h18, 1'b1);
        flush = 1'b1; redirect_pc = 32'h200; resolve_valid = 1'b1; taken = 1'b1;
        tick(); chk_nop("f_flush", 1'b0);
        flush = 1'b0; resolve_valid = 1'b0; taken = 1'b0;
        tick(); chk_pair("f_tgt", 32'h200, 32'h200, 1'b0);
        tick(); chk_pair("f_next", 32'h204, 32'h204, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
